// File: rtl/fetch_seq.sv
// fetch_seq: mcpu instruction fetch/execute sequencer with a req/ack memory handshake,
// variable-length operand fetch, branch/halt control and a sticky memory-timeout fault.
module fetch_seq #(
    parameter int AW = 16,
    parameter int MW = 8,
    parameter int OPW = 8,
    parameter int MAXOPL = 8,
    parameter int TIMEOUT = 16,
    parameter logic [AW-1:0] RESET_PC = '0,
    localparam int LW = $clog2(MAXOPL + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_run,
    output logic                 o_mem_req,
    output logic [AW-1:0]        o_mem_addr,
    input  logic                 i_mem_ack,
    input  logic [MW-1:0]        i_mem_rdata,
    input  logic [LW-1:0]        i_opl_len,
    output logic                 o_exe,
    input  logic                 i_exe_done,
    input  logic                 i_hlt,
    input  logic                 i_br_take,
    input  logic [AW-1:0]        i_br_tgt,
    output logic [OPW-1:0]       o_opc,
    output logic [MAXOPL*MW-1:0] o_opl,
    output logic [AW-1:0]        o_pc,
    output logic [2:0]           o_cs,
    output logic                 o_fault
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_OPCFT = 3'd1,
        S_OPLFT = 3'd2,
        S_EXE   = 3'd3,
        S_HALT  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    state_t              r_state;
    logic [AW-1:0]       r_pc;
    logic [OPW-1:0]      r_opc;
    logic [MAXOPL*MW-1:0] r_opl;
    logic [LW-1:0]       r_idx;
    logic [CW-1:0]       r_cnt;
    logic                r_exe;
    logic                r_fault;
    logic                r_run_q;

    logic [LW-1:0]       w_len;
    logic                w_req;
    logic                w_run_edge;
    logic                w_timeout;

    // Oversized operand counts from the external decoder are clamped to the register capacity.
    assign w_len      = (i_opl_len > LW'(MAXOPL)) ? LW'(MAXOPL) : i_opl_len;
    assign w_req      = (r_state == S_OPCFT) || ((r_state == S_OPLFT) && (r_idx < w_len));
    assign w_run_edge = i_run & ~r_run_q;
    assign w_timeout  = (TIMEOUT != 0) && w_req && !i_mem_ack && (r_cnt == CW'(TIMEOUT - 1));

    assign o_mem_req  = w_req;
    assign o_mem_addr = r_pc;
    assign o_exe      = r_exe;
    assign o_opc      = r_opc;
    assign o_opl      = r_opl;
    assign o_pc       = r_pc;
    assign o_cs       = r_state;
    assign o_fault    = r_fault;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_opc   <= '0;
            r_opl   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_exe   <= 1'b0;
            r_fault <= 1'b0;
            r_run_q <= 1'b0;
        end else begin
            r_run_q <= i_run;
            r_exe   <= 1'b0;

            // The wait counter only runs while a request is stalled; any ack or exit clears it.
            if ((TIMEOUT != 0) && w_req && !i_mem_ack && !w_timeout) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
            end

            case (r_state)
                S_IDLE, S_HALT: begin
                    if (w_run_edge) begin
                        r_state <= S_OPCFT;
                    end
                end
                S_OPCFT: begin
                    if (i_mem_ack) begin
                        r_opc   <= i_mem_rdata[OPW-1:0];
                        r_opl   <= '0;
                        r_idx   <= '0;
                        r_pc    <= r_pc + AW'(1);
                        r_state <= S_OPLFT;
                    end else if (w_timeout) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                    end
                end
                S_OPLFT: begin
                    if (!w_req) begin
                        r_state <= S_EXE;
                        r_exe   <= 1'b1;
                    end else if (i_mem_ack) begin
                        for (int k = 0; k < MAXOPL; k++) begin
                            if (r_idx == LW'(k)) begin
                                r_opl[k*MW +: MW] <= i_mem_rdata;
                            end
                        end
                        r_pc  <= r_pc + AW'(1);
                        r_idx <= r_idx + LW'(1);
                        if (r_idx + LW'(1) == w_len) begin
                            r_state <= S_EXE;
                            r_exe   <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                    end
                end
                S_EXE: begin
                    if (i_exe_done) begin
                        if (i_hlt) begin
                            r_state <= S_HALT;
                        end else begin
                            if (i_br_take) begin
                                r_pc <= i_br_tgt;
                            end
                            r_state <= S_OPCFT;
                        end
                    end else begin
                        r_exe <= 1'b1;
                    end
                end
                S_FAULT: begin
                    r_fault <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: directed bench for fetch_seq with a behavioural memory responder and a
// scoreboard of expected opcode/operand/pc results popped whenever the DUT enters EXE.
module tb_fetch_seq;

    logic        clock;
    logic        rstN;
    logic        run;
    logic        memReq;
    logic [15:0] memAddr;
    logic        memAck;
    logic [7:0]  memRdata;
    logic [3:0]  oplLen;
    logic        exe;
    logic        exeDone;
    logic        hlt;
    logic        brTake;
    logic [15:0] brTgt;
    logic [7:0]  opc;
    logic [63:0] opl;
    logic [15:0] pc;
    logic [2:0]  cs;
    logic        fault;

    typedef struct {
        logic [7:0]  opc;
        logic [63:0] opl;
        logic [15:0] pc;
    } instrExp_t;

    instrExp_t   sb[$];
    int          checks = 0;
    int          failures = 0;

    logic [7:0]  mem [0:65535];
    logic [3:0]  lenTab [0:255];
    int          ackLatency = 0;
    bit          ackEnable = 1'b1;
    bit          forceAck = 1'b0;
    int          waitCnt;
    int          oplAcks = 0;
    int          oplAcksBase;

    fetch_seq #(
        .AW(16), .MW(8), .OPW(8), .MAXOPL(8), .TIMEOUT(4), .RESET_PC(16'hFFFF)
    ) dut (
        .i_clk(clock), .i_rst_n(rstN), .i_run(run),
        .o_mem_req(memReq), .o_mem_addr(memAddr), .i_mem_ack(memAck), .i_mem_rdata(memRdata),
        .i_opl_len(oplLen), .o_exe(exe), .i_exe_done(exeDone), .i_hlt(hlt),
        .i_br_take(brTake), .i_br_tgt(brTgt), .o_opc(opc), .o_opl(opl), .o_pc(pc),
        .o_cs(cs), .o_fault(fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign memAck   = forceAck | (ackEnable && memReq && (waitCnt >= ackLatency));
    assign memRdata = mem[memAddr];
    assign oplLen   = lenTab[opc];

    always @(posedge clock or negedge rstN) begin
        if (!rstN) begin
            waitCnt <= 0;
        end else if (memReq && !memAck) begin
            waitCnt <= waitCnt + 1;
        end else begin
            waitCnt <= 0;
        end
    end

    always @(posedge clock) begin
        if (cs == 3'd2 && memReq && memAck) begin
            oplAcks <= oplAcks + 1;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic expectInstr(input logic [7:0] eOpc, input logic [63:0] eOpl, input logic [15:0] ePc);
        instrExp_t e;
        e.opc = eOpc;
        e.opl = eOpl;
        e.pc  = ePc;
        sb.push_back(e);
    endtask

    task automatic waitExe(input int budget);
        instrExp_t e;
        int n = 0;
        while (exe !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checkOutput("exe_reached", {63'b0, exe}, 64'd1);
        e = sb.pop_front();
        checkOutput("sb_opc", {56'b0, opc}, {56'b0, e.opc});
        checkOutput("sb_opl", opl, e.opl);
        checkOutput("sb_pc", {48'b0, pc}, {48'b0, e.pc});
    endtask

    task automatic finishExe(input bit h, input bit b, input logic [15:0] t);
        exeDone = 1'b1;
        hlt     = h;
        brTake  = b;
        brTgt   = t;
        tick();
        exeDone = 1'b0;
        hlt     = 1'b0;
        brTake  = 1'b0;
        brTgt   = 16'h0;
    endtask

    initial begin
        rstN = 1'b0; run = 1'b0; exeDone = 1'b0; hlt = 1'b0; brTake = 1'b0; brTgt = 16'h0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 256; i++) lenTab[i] = 4'd0;
        lenTab[8'h85] = 4'd1;
        lenTab[8'h03] = 4'd3;
        lenTab[8'h0C] = 4'd12;
        mem[16'hFFFF] = 8'h01;
        mem[16'h0000] = 8'h85; mem[16'h0001] = 8'h2A;
        mem[16'h0002] = 8'h03; mem[16'h0003] = 8'h11; mem[16'h0004] = 8'h22; mem[16'h0005] = 8'h33;
        mem[16'h0006] = 8'h01;
        mem[16'h0100] = 8'h0C;
        for (int i = 0; i < 8; i++) mem[16'h0101 + i] = 8'hA0 + 8'(i);
        mem[16'h0109] = 8'h01;
        mem[16'h010A] = 8'h01;

        tick();
        tick();
        checkOutput("rst_cs", {61'b0, cs}, 64'd0);
        checkOutput("rst_pc", {48'b0, pc}, 64'hFFFF);
        checkOutput("rst_opc", {56'b0, opc}, 64'd0);
        checkOutput("rst_opl", opl, 64'd0);
        checkOutput("rst_req", {63'b0, memReq}, 64'd0);
        checkOutput("rst_exe", {63'b0, exe}, 64'd0);
        checkOutput("rst_fault", {63'b0, fault}, 64'd0);
        rstN = 1'b1;
        tick();
        checkOutput("idle_no_run", {61'b0, cs}, 64'd0);

        // Zero-operand instruction at 0xFFFF wraps pc and spends exactly one OPLFT cycle.
        expectInstr(8'h01, 64'h0, 16'h0000);
        applyStimulus();
        checkOutput("wrap_cs_opcft", {61'b0, cs}, 64'd1);
        tick();
        checkOutput("wrap_cs_oplft", {61'b0, cs}, 64'd2);
        checkOutput("wrap_pc", {48'b0, pc}, 64'h0000);
        checkOutput("wrap_no_req", {63'b0, memReq}, 64'd0);
        tick();
        checkOutput("wrap_cs_exe", {61'b0, cs}, 64'd3);
        waitExe(5);
        finishExe(1'b1, 1'b0, 16'h0);
        checkOutput("halt1_cs", {61'b0, cs}, 64'd4);

        // One-operand instruction with zero-latency acks: EXE in the fourth cycle.
        expectInstr(8'h85, 64'h2A, 16'h0002);
        applyStimulus();
        checkOutput("t1_cs1", {61'b0, cs}, 64'd1);
        checkOutput("t1_addr", {48'b0, memAddr}, 64'h0000);
        tick();
        checkOutput("t1_cs2", {61'b0, cs}, 64'd2);
        checkOutput("t1_pc1", {48'b0, pc}, 64'h0001);
        tick();
        checkOutput("t1_cs3", {61'b0, cs}, 64'd3);
        waitExe(0);
        tick();
        checkOutput("exe_hold_cs", {61'b0, cs}, 64'd3);
        checkOutput("exe_hold_exe", {63'b0, exe}, 64'd1);

        // Three operands with two wait cycles per word; address must stay put while waiting.
        ackLatency = 2;
        expectInstr(8'h03, 64'h332211, 16'h0006);
        finishExe(1'b0, 1'b0, 16'h0);
        for (int w = 0; w < 4; w++) begin
            for (int c = 0; c < 3; c++) begin
                checkOutput("t2_req", {63'b0, memReq}, 64'd1);
                checkOutput("t2_addr", {48'b0, memAddr}, 64'(16'h0002 + 16'(w)));
                checkOutput("t2_cs", {61'b0, cs}, (w == 0) ? 64'd1 : 64'd2);
                tick();
            end
        end
        waitExe(2);

        ackLatency = 0;
        expectInstr(8'h01, 64'h0, 16'h0007);
        finishExe(1'b0, 1'b0, 16'h0);
        waitExe(5);

        // Taken branch, then an over-long operand count clamped to eight fetches.
        oplAcksBase = oplAcks;
        expectInstr(8'h0C, 64'hA7A6A5A4A3A2A1A0, 16'h0109);
        finishExe(1'b0, 1'b1, 16'h0100);
        checkOutput("br_addr", {48'b0, memAddr}, 64'h0100);
        checkOutput("br_req", {63'b0, memReq}, 64'd1);
        waitExe(30);
        checkOutput("clamp_fetches", 64'(oplAcks - oplAcksBase), 64'd8);

        // Halt wins over branch; held run and stray acks must not resume.
        run = 1'b1;
        tick();
        finishExe(1'b1, 1'b1, 16'h0200);
        checkOutput("halt_cs", {61'b0, cs}, 64'd4);
        checkOutput("halt_pc", {48'b0, pc}, 64'h0109);
        tick();
        tick();
        forceAck = 1'b1;
        tick();
        tick();
        forceAck = 1'b0;
        checkOutput("held_run_cs", {61'b0, cs}, 64'd4);
        checkOutput("stray_ack_pc", {48'b0, pc}, 64'h0109);
        checkOutput("stray_ack_opc", {56'b0, opc}, 64'h0C);
        run = 1'b0;
        tick();
        expectInstr(8'h01, 64'h0, 16'h010A);
        applyStimulus();
        checkOutput("resume_addr", {48'b0, memAddr}, 64'h0109);
        waitExe(5);

        // Ack arriving in the last allowed wait cycle beats the timeout.
        ackLatency = 3;
        expectInstr(8'h01, 64'h0, 16'h010B);
        finishExe(1'b0, 1'b0, 16'h0);
        tick();
        tick();
        tick();
        checkOutput("to_edge_cs", {61'b0, cs}, 64'd1);
        tick();
        checkOutput("to_edge_oplft", {61'b0, cs}, 64'd2);
        checkOutput("to_edge_fault", {63'b0, fault}, 64'd0);
        waitExe(5);

        // No ack at all: fault after four wait cycles, and it is sticky.
        ackEnable = 1'b0;
        finishExe(1'b0, 1'b0, 16'h0);
        tick();
        tick();
        tick();
        checkOutput("to_w4_cs", {61'b0, cs}, 64'd1);
        checkOutput("to_w4_req", {63'b0, memReq}, 64'd1);
        tick();
        checkOutput("fault_cs", {61'b0, cs}, 64'd5);
        checkOutput("fault_flag", {63'b0, fault}, 64'd1);
        checkOutput("fault_req", {63'b0, memReq}, 64'd0);
        applyStimulus();
        tick();
        checkOutput("fault_sticky", {61'b0, cs}, 64'd5);

        // Reset mid operand fetch clears the partial operand immediately.
        ackEnable  = 1'b1;
        ackLatency = 2;
        mem[16'hFFFF] = 8'h03;
        mem[16'h0000] = 8'h11; mem[16'h0001] = 8'h22; mem[16'h0002] = 8'h33;
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        tick();
        applyStimulus();
        for (int n = 0; n < 20 && opl == 64'd0; n++) tick();
        checkOutput("mid_opl", opl, 64'h11);
        checkOutput("mid_cs", {61'b0, cs}, 64'd2);
        rstN = 1'b0;
        #1;
        checkOutput("arst_cs", {61'b0, cs}, 64'd0);
        checkOutput("arst_req", {63'b0, memReq}, 64'd0);
        checkOutput("arst_opl", opl, 64'd0);
        tick();
        rstN = 1'b1;
        for (int n = 0; n < 5; n++) tick();
        checkOutput("post_rst_cs", {61'b0, cs}, 64'd0);
        checkOutput("post_rst_exe", {63'b0, exe}, 64'd0);
        expectInstr(8'h03, 64'h332211, 16'h0003);
        applyStimulus();
        waitExe(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
